thread_dispatcher: RTL

THREAD_DISPATCHER -- requirements
Module: thread_dispatcher

---
 rtl/thread_pkg.sv | 16 +
 rtl/rr_free_select.sv | 32 +++
 rtl/thread_dispatcher.sv | 120 ++++++++++++
 3 files changed

// File: rtl/thread_pkg.sv
// Shared defaults and FSM encoding for the frame job dispatcher and the
// worker thread array it feeds.
package thread_pkg;

  localparam int DEF_N_THREADS = 16;
  localparam int DEF_N_JOBS    = 307200;
  localparam int DEF_JOB_W     = 19;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_DRAIN,
    ST_FINISH
  } state_e;

endpackage

// File: rtl/rr_free_select.sv
// Round-robin free-slot finder: first clear bit of busy_mask_i at or after
// rr_ptr_i, wrapping modulo N_THREADS.
module rr_free_select #(
  parameter int N_THREADS = 16,
  parameter int IDX_W     = (N_THREADS > 1) ? $clog2(N_THREADS) : 1
) (
  input  logic [N_THREADS-1:0] busy_mask_i,
  input  logic [IDX_W-1:0]     rr_ptr_i,
  output logic                 found_o,
  output logic [IDX_W-1:0]     idx_o
);

  logic [IDX_W:0] cand;

  // Scan from the farthest offset down so the nearest free slot wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = N_THREADS - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr_i} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(N_THREADS)) begin
        cand = cand - (IDX_W + 1)'(N_THREADS);
      end
      if (!busy_mask_i[cand[IDX_W-1:0]]) begin
        found_o = 1'b1;
        idx_o   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/thread_dispatcher.sv
// Hands out one job index per cycle to free worker threads in round-robin
// order until a frame's worth of jobs is issued, then waits for all to retire.
module thread_dispatcher
  import thread_pkg::*;
#(
  parameter int N_THREADS = DEF_N_THREADS,
  parameter int N_JOBS    = DEF_N_JOBS,
  parameter int JOB_W     = DEF_JOB_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_THREADS-1:0] thread_done,
  output logic [N_THREADS-1:0] job_valid,
  output logic [JOB_W-1:0]     job_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int IDX_W = (N_THREADS > 1) ? $clog2(N_THREADS) : 1;

  state_e               state_q, state_d;
  logic [N_THREADS-1:0] mask_q, mask_d, mask_clr;
  logic [JOB_W:0]       next_q, next_d;
  logic [IDX_W-1:0]     rr_q, rr_d, sel_idx;
  logic                 sel_found;
  logic [N_THREADS-1:0] valid_q, valid_d;
  logic [JOB_W-1:0]     idx_q, idx_d;
  logic                 busy_q, busy_d, done_q, done_d, err_q, err_d;

  // Retirements this cycle free their slot for immediate reissue.
  assign mask_clr = mask_q & ~thread_done;

  rr_free_select #(
    .N_THREADS (N_THREADS),
    .IDX_W     (IDX_W)
  ) u_sel (
    .busy_mask_i (mask_clr),
    .rr_ptr_i    (rr_q),
    .found_o     (sel_found),
    .idx_o       (sel_idx)
  );

  always_comb begin
    state_d = state_q;
    mask_d  = mask_clr;
    next_d  = next_q;
    rr_d    = rr_q;
    valid_d = '0;
    idx_d   = '0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q | (|(thread_done & ~mask_q));
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DISPATCH;
          next_d  = '0;
          rr_d    = '0;
          busy_d  = 1'b1;
        end
      end
      ST_DISPATCH: begin
        if (sel_found) begin
          valid_d[sel_idx] = 1'b1;
          idx_d            = next_q[JOB_W-1:0];
          mask_d[sel_idx]  = 1'b1;
          next_d           = next_q + 1'b1;
          rr_d = (sel_idx == IDX_W'(N_THREADS - 1)) ? '0 : sel_idx + 1'b1;
          if (next_q == (JOB_W + 1)'(N_JOBS - 1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (mask_clr == '0) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      next_q  <= '0;
      rr_q    <= '0;
      valid_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      next_q  <= next_d;
      rr_q    <= rr_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign job_valid = valid_q;
  assign job_idx   = idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
